// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, response codes and FSM encoding for the bus slave port.
package bus_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        RSP_OKAY  = 2'b00,
        RSP_ERROR = 2'b01,
        RSP_RETRY = 2'b10,
        RSP_SPLIT = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DECODE,
        S_SPLIT,
        S_WDATA,
        S_RDATA,
        S_RESP
    } state_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction
endpackage

// File: rtl/ser_shift.sv
// ser_shift: shift register with parallel load; shifts serial data in at the LSB, MSB is the serial output.
module ser_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic         i_ser,
    input  logic [W-1:0] i_par,
    output logic [W-1:0] o_par
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst)
            r_q <= '0;
        else if (i_load)
            r_q <= i_par;
        else if (i_shift)
            r_q <= {r_q[W-2:0], i_ser};
    end

    assign o_par = r_q;
endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: serially addressed register-file slave with OKAY/ERROR/RETRY/SPLIT responses.
module bus_slave_port
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       read_write,
    input  logic       a_in,
    input  logic       d_in,
    input  logic       hold,
    output logic       d_out,
    output logic       d_out_valid,
    output logic       ready,
    output logic [1:0] response,
    output logic       split
);
    state_e r_state, w_next;
    resp_e r_resp, w_resp;
    logic [CNT_W-1:0] r_cnt;
    logic r_rw, r_wr_pend;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [IDX_W-1:0] w_idx;
    logic w_addr_shift, w_data_shift, w_data_load, w_cnt_clr, w_cnt_inc, w_we, w_wr_pend_set;

    assign w_idx = w_addr[IDX_W-1:0];

    ser_shift #(.W(ADDR_W)) u_addr (
        .clk    (clk),
        .rst    (rst),
        .i_load (1'b0),
        .i_shift(w_addr_shift),
        .i_ser  (a_in),
        .i_par  ('0),
        .o_par  (w_addr)
    );

    // One data register serves both directions: shifts d_in in for writes, shifts the loaded word out for reads.
    ser_shift #(.W(DATA_W)) u_data (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_data_load),
        .i_shift(w_data_shift),
        .i_ser  (d_in),
        .i_par  (r_mem[w_idx]),
        .o_par  (w_data)
    );

    always_comb begin
        w_next        = r_state;
        w_resp        = r_resp;
        w_addr_shift  = 1'b0;
        w_data_shift  = 1'b0;
        w_data_load   = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_we          = 1'b0;
        w_wr_pend_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next    = sel ? S_ADDR : S_IDLE;
                w_cnt_clr = sel;
            end
            S_ADDR: begin
                if (!sel) begin
                    w_next = S_RESP;
                    w_resp = RSP_RETRY;
                end else begin
                    w_addr_shift = 1'b1;
                    w_next       = (r_cnt == CNT_W'(ADDR_W - 1)) ? S_DECODE : S_ADDR;
                    w_cnt_clr    = r_cnt == CNT_W'(ADDR_W - 1);
                    w_cnt_inc    = r_cnt != CNT_W'(ADDR_W - 1);
                end
            end
            S_DECODE: begin
                if (!addr_in_range(w_addr)) begin
                    w_next = S_RESP;
                    w_resp = RSP_ERROR;
                end else begin
                    w_next      = hold ? S_SPLIT : r_rw ? S_WDATA : S_RDATA;
                    w_data_load = !hold && !r_rw;
                end
            end
            S_SPLIT: begin
                w_next      = hold ? S_SPLIT : r_rw ? S_WDATA : S_RDATA;
                w_data_load = !hold && !r_rw;
            end
            S_WDATA: begin
                // The extra commit cycle after the last bit writes memory regardless of sel.
                if (r_wr_pend) begin
                    w_we   = 1'b1;
                    w_next = S_RESP;
                    w_resp = RSP_OKAY;
                end else if (!sel) begin
                    w_next = S_RESP;
                    w_resp = RSP_RETRY;
                end else begin
                    w_data_shift  = 1'b1;
                    w_wr_pend_set = r_cnt == CNT_W'(DATA_W - 1);
                    w_cnt_inc     = r_cnt != CNT_W'(DATA_W - 1);
                end
            end
            S_RDATA: begin
                if (!sel) begin
                    w_next = S_RESP;
                    w_resp = RSP_RETRY;
                end else begin
                    w_data_shift = 1'b1;
                    w_next       = (r_cnt == CNT_W'(DATA_W - 1)) ? S_RESP : S_RDATA;
                    w_resp       = (r_cnt == CNT_W'(DATA_W - 1)) ? RSP_OKAY : r_resp;
                    w_cnt_inc    = r_cnt != CNT_W'(DATA_W - 1);
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_resp    <= RSP_OKAY;
            r_cnt     <= '0;
            r_rw      <= 1'b0;
            r_wr_pend <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_resp    <= w_resp;
            r_cnt     <= w_cnt_clr ? '0 : w_cnt_inc ? r_cnt + CNT_W'(1) : r_cnt;
            r_rw      <= (r_state == S_IDLE && sel) ? read_write : r_rw;
            r_wr_pend <= w_wr_pend_set;
            if (w_we)
                r_mem[w_idx] <= w_data;
        end
    end

    assign split       = (r_state == S_SPLIT) && hold;
    assign ready       = (r_state == S_IDLE) || (r_state == S_RESP);
    assign response    = (r_state == S_RESP) ? r_resp : split ? RSP_SPLIT : RSP_OKAY;
    assign d_out_valid = r_state == S_RDATA;
    assign d_out       = d_out_valid & w_data[DATA_W-1];
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed transactions; expected responses and read bits are queued and checked by a monitor.
module tb_bus_slave_port;
    logic clk = 1'b0;
    logic rst, sel, read_write, a_in, d_in, hold;
    logic d_out, d_out_valid, ready, split;
    logic [1:0] response;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int split_cnt = 0;
    logic [1:0] q_resp[$];
    logic q_bits[$];
    logic [7:0] m[16];
    logic prev_ready = 1'b1;
    logic prev_rst = 1'b0;

    bus_slave_port dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .read_write (read_write),
        .a_in       (a_in),
        .d_in       (d_in),
        .hold       (hold),
        .d_out      (d_out),
        .d_out_valid(d_out_valid),
        .ready      (ready),
        .response   (response),
        .split      (split)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: consumes expected read bits and end-of-transaction responses as the DUT presents them.
    always @(negedge clk) begin
        if (d_out_valid) begin
            if (q_bits.size() == 0)
                chk("dout_unexpected", 32'(d_out_valid), 32'(0));
            else
                chk("dout_bit", 32'(d_out), 32'(q_bits.pop_front()));
        end else
            chk("dout_idle_zero", 32'(d_out), 32'(0));
        if (split) begin
            split_cnt++;
            chk("split_resp", 32'(response), 32'(2'b11));
        end
        if (ready && !prev_ready && prev_rst && rst) begin
            if (q_resp.size() == 0)
                chk("resp_unexpected", 32'(response), 32'hFFFF);
            else
                chk("resp_code", 32'(response), 32'(q_resp.pop_front()));
        end else if (ready && prev_ready && rst)
            chk("idle_resp", 32'(response), 32'(0));
        prev_ready <= ready;
        prev_rst   <= rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic rw, input logic [11:0] addr, input logic [7:0] wd,
                        input logic [1:0] exp_resp, input int exp_lat, input int n_hold,
                        input int abort_at, input int rst_at, input bit keep_sel);
        int start;
        logic [7:0] rd;
        rd = m[addr[3:0]];
        q_resp.push_back(exp_resp);
        if (!rw && exp_resp == 2'b00)
            for (int i = 7; i >= 0; i--) q_bits.push_back(rd[i]);
        split_cnt = 0;
        sel = 1'b1;
        read_write = rw;
        step();
        start = cyc;
        for (int i = 11; i >= 0; i--) begin
            a_in = addr[i];
            step();
        end
        a_in = 1'b0;
        hold = n_hold > 0;
        step();
        if (n_hold > 0) begin
            sel = 1'b0;
            repeat (n_hold) step();
            hold = 1'b0;
            sel = 1'b1;
            step();
        end
        if (addr < 12'd16) begin
            if (rw) begin
                for (int b = 0; b < 8; b++) begin
                    if (b == abort_at) begin
                        sel = 1'b0;
                        break;
                    end
                    d_in = wd[7-b];
                    step();
                end
            end else if (rst_at >= 0) begin
                repeat (rst_at) step();
                rst = 1'b0;
                sel = 1'b0;
                step();
                rst = 1'b1;
                chk("rst_ready", 32'(ready), 32'(1));
                chk("rst_dvalid", 32'(d_out_valid), 32'(0));
                chk("rst_resp", 32'(response), 32'(0));
                chk("rst_split", 32'(split), 32'(0));
                q_bits.delete();
                void'(q_resp.pop_back());
                for (int i = 0; i < 16; i++) m[i] = 8'h00;
                return;
            end
        end
        for (int w = 0; w < 40 && !ready; w++) step();
        chk("resp_ready", 32'(ready), 32'(1));
        chk("latency", 32'(cyc - start), 32'(exp_lat));
        if (n_hold > 0)
            chk("split_cycles", 32'(split_cnt), 32'(n_hold));
        if (rw && exp_resp == 2'b00)
            m[addr[3:0]] = wd;
        if (!keep_sel)
            sel = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        rst = 1'b0; sel = 1'b0; read_write = 1'b0; a_in = 1'b0; d_in = 1'b0; hold = 1'b0;
        repeat (3) step();
        chk("reset_ready", 32'(ready), 32'(1));
        chk("reset_resp", 32'(response), 32'(0));
        chk("reset_split", 32'(split), 32'(0));
        chk("reset_dvalid", 32'(d_out_valid), 32'(0));
        chk("reset_dout", 32'(d_out), 32'(0));
        rst = 1'b1;
        // write 0xA5 then read back 1,0,1,0,0,1,0,1
        xfer(1'b1, 12'h003, 8'hA5, 2'b00, 22, 0, -1, -1, 1'b0);
        xfer(1'b0, 12'h003, 8'h00, 2'b00, 21, 0, -1, -1, 1'b0);
        // out-of-range: ERROR, aliasing word 0 untouched
        xfer(1'b1, 12'h010, 8'h77, 2'b01, 13, 0, -1, -1, 1'b0);
        xfer(1'b0, 12'h000, 8'h00, 2'b00, 21, 0, -1, -1, 1'b0);
        xfer(1'b0, 12'hFFF, 8'h00, 2'b01, 13, 0, -1, -1, 1'b0);
        // split for 5 cycles with sel dropped meanwhile
        xfer(1'b1, 12'h007, 8'h3C, 2'b00, 28, 5, -1, -1, 1'b0);
        xfer(1'b0, 12'h007, 8'h00, 2'b00, 21, 0, -1, -1, 1'b0);
        // abort after 4 data bits keeps 0xA5
        xfer(1'b1, 12'h003, 8'hFF, 2'b10, 18, 0, 4, -1, 1'b0);
        xfer(1'b0, 12'h003, 8'h00, 2'b00, 21, 0, -1, -1, 1'b0);
        // back-to-back with sel held high, top in-range word
        xfer(1'b1, 12'h00F, 8'hC3, 2'b00, 22, 0, -1, -1, 1'b1);
        xfer(1'b0, 12'h00F, 8'h00, 2'b00, 21, 0, -1, -1, 1'b1);
        xfer(1'b0, 12'h007, 8'h00, 2'b00, 21, 0, -1, -1, 1'b0);
        // reset in the middle of RDATA clears everything
        xfer(1'b0, 12'h003, 8'h00, 2'b00, 0, 0, -1, 3, 1'b0);
        for (int i = 0; i < 16; i++)
            xfer(1'b0, 12'(i), 8'h00, 2'b00, 21, 0, -1, -1, i < 15);
        repeat (3) step();
        chk("resp_queue_empty", 32'(q_resp.size()), 32'(0));
        chk("bit_queue_empty", 32'(q_bits.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
